// File: rtl/present80_round_step.sv
// present80_round_step: one registered PRESENT-80 round (key addition,
// S-box layer, bit permutation) merged with one key-schedule step.
// The round counter is owned by the outer controller and arrives on rc.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     capture this cycle's state_in/key_in/rc
//   state_in     64-bit cipher state entering the round
//   key_in       80-bit key register entering the round
//   rc           5-bit round counter (any value accepted, 0 included)
//   out_valid    high exactly one cycle after an accepted in_valid
//   state_out    registered round result
//   key_out      registered next key register
//   whiten_out   combinational key addition state_in ^ key_in[79:16]
//   whiten_q     (PRESENT_WHITEN_REG_EN only) registered copy of whiten_out,
//                captured on accepted in_valid
//
// Optional feature macro: PRESENT_WHITEN_REG_EN
module present80_round_step (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] state_in,
    input  logic [79:0] key_in,
    input  logic [4:0]  rc,
    output logic        out_valid,
    output logic [63:0] state_out,
    output logic [79:0] key_out,
`ifdef PRESENT_WHITEN_REG_EN
    output logic [63:0] whiten_q,
`endif
    output logic [63:0] whiten_out
);

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 80;
    localparam int unsigned NIBBLES = BLOCK_W / 4;

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [BLOCK_W-1:0] add_c;
    logic [BLOCK_W-1:0] sub_c;
    logic [BLOCK_W-1:0] perm_c;
    logic [KEY_W-1:0]   key_rot_c;
    logic [KEY_W-1:0]   key_next_c;

    // Key addition, shared by the round datapath and the whitening output
    assign add_c      = state_in ^ key_in[79:16];
    assign whiten_out = add_c;

    // S-box layer: every nibble substituted independently
    for (genvar n = 0; n < NIBBLES; n++) begin : g_sbox
        assign sub_c[4*n +: 4] = sbox(add_c[4*n +: 4]);
    end

    // Bit permutation: bit i moves to 16*i mod 63, bit 63 stays put
    for (genvar b = 0; b < BLOCK_W - 1; b++) begin : g_perm
        assign perm_c[(16 * b) % 63] = sub_c[b];
    end
    assign perm_c[BLOCK_W-1] = sub_c[BLOCK_W-1];

    // Key schedule: rotate left 61, substitute top nibble, fold in round counter
    assign key_rot_c  = {key_in[18:0], key_in[79:19]};
    assign key_next_c = {sbox(key_rot_c[79:76]),
                         key_rot_c[75:20],
                         key_rot_c[19:15] ^ rc,
                         key_rot_c[14:0]};

    logic               valid_d, valid_q;
    logic [BLOCK_W-1:0] state_d, state_q;
    logic [KEY_W-1:0]   key_d,   key_q;

    // Next-state: capture on in_valid, otherwise hold the last result
    always_comb begin
        valid_d = in_valid;
        state_d = state_q;
        key_d   = key_q;
        if (in_valid) begin
            state_d = perm_c;
            key_d   = key_next_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign out_valid = valid_q;
    assign state_out = state_q;
    assign key_out   = key_q;

`ifdef PRESENT_WHITEN_REG_EN
    logic [BLOCK_W-1:0] whiten_reg_d, whiten_reg_q;

    // Registered whitening so the final ciphertext lines up with out_valid
    always_comb begin
        whiten_reg_d = whiten_reg_q;
        if (in_valid) begin
            whiten_reg_d = add_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whiten_reg_q <= '0;
        end else begin
            whiten_reg_q <= whiten_reg_d;
        end
    end

    assign whiten_q = whiten_reg_q;
`endif

endmodule

// File: tb/tb_present80_round_step.sv
// Testbench for present80_round_step: randomized and directed stimulus checked
// against a behavioural PRESENT-80 model built from table lookups and loops.
module tb_present80_round_step;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] state_in;
    logic [79:0] key_in;
    logic [4:0]  rc;
    logic        out_valid;
    logic [63:0] state_out;
    logic [79:0] key_out;
    logic [63:0] whiten_out;
`ifdef PRESENT_WHITEN_REG_EN
    logic [63:0] whiten_q;
`endif

    int checks;
    int failures;

    present80_round_step dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .state_in   (state_in),
        .key_in     (key_in),
        .rc         (rc),
        .out_valid  (out_valid),
        .state_out  (state_out),
        .key_out    (key_out),
`ifdef PRESENT_WHITEN_REG_EN
        .whiten_q   (whiten_q),
`endif
        .whiten_out (whiten_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [63:0] m_round(input logic [63:0] s, input logic [79:0] k);
        logic [63:0] a, sb, p;
        int dst;
        a = s ^ k[79:16];
        for (int n = 0; n < 16; n++) sb[4*n +: 4] = sbox_tbl[a[4*n +: 4]];
        p = '0;
        for (int i = 0; i < 64; i++) begin
            dst = (i == 63) ? 63 : (16 * i) % 63;
            p[dst] = sb[i];
        end
        return p;
    endfunction

    function automatic logic [79:0] m_key(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        for (int i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
        t[79:76] = sbox_tbl[t[79:76]];
        t[19:15] = t[19:15] ^ r;
        return t;
    endfunction

    function automatic logic [79:0] rand_key();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1;
        state_in = {$urandom, $urandom}; key_in = rand_key(); rc = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_out !== 64'h0 || key_out !== 80'h0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b state_out=%h key_out=%h, required 0/0/0",
                     out_valid, state_out, key_out);
        end
`ifdef PRESENT_WHITEN_REG_EN
        checks++;
        if (whiten_q !== 64'h0) begin
            failures++;
            $display("FAIL reset_whiten_q: got %h required 0", whiten_q);
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_round();
        @(negedge clk);
        state_in = 64'h0; key_in = 80'h0; rc = 5'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || state_out !== 64'hFFFFFFFF00000000 ||
            key_out !== 80'hC0000000000000008000) begin
            failures++;
            $display("FAIL t1_round: v=%b state=%h key=%h, required 1 FFFFFFFF00000000 C0000000000000008000",
                     out_valid, state_out, key_out);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_valid_pulse: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic run_encrypt(input logic [63:0] m, input logic [79:0] k,
                               input logic [63:0] exp_c, input string name);
        logic [63:0] st, ms, ms_n;
        logic [79:0] ky, mk;
        int step_bad;
        st = m; ky = k; ms = m; mk = k; step_bad = 0;
        for (int r = 1; r <= 31; r++) begin
            @(negedge clk);
            state_in = st; key_in = ky; rc = 5'(r); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            ms_n = m_round(ms, mk);
            mk   = m_key(mk, 5'(r));
            ms   = ms_n;
            checks++;
            if (out_valid !== 1'b1 || state_out !== ms || key_out !== mk) begin
                failures++;
                if (step_bad < 3)
                    $display("FAIL %s_step%0d: state=%h key=%h v=%b, required state=%h key=%h v=1",
                             name, r, state_out, key_out, out_valid, ms, mk);
                step_bad++;
            end
            st = state_out; ky = key_out;
        end
        state_in = st; key_in = ky;
        #1;
        checks++;
        if (whiten_out !== exp_c) begin
            failures++;
            $display("FAIL %s_cipher: whiten_out=%h required %h", name, whiten_out, exp_c);
        end
`ifdef PRESENT_WHITEN_REG_EN
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (whiten_q !== exp_c) begin
            failures++;
            $display("FAIL %s_whiten_q: got %h required %h", name, whiten_q, exp_c);
        end
`endif
    endtask

    task automatic test_full_vectors();
        run_encrypt(64'h0, 80'h0, 64'h5579C1387B228445, "t2");
        run_encrypt(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "t3");
        run_encrypt({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "t4a");
        run_encrypt({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, "t4b");
    endtask

    task automatic test_random_rounds();
        logic [63:0] s, es;
        logic [79:0] k, ek;
        logic [4:0]  r;
        for (int i = 0; i < 40; i++) begin
            s = {$urandom, $urandom}; k = rand_key();
            r = (i < 2) ? 5'd0 : 5'($urandom_range(0, 31));
            es = m_round(s, k); ek = m_key(k, r);
            @(negedge clk);
            state_in = s; key_in = k; rc = r; in_valid = 1'b1;
            #1;
            checks++;
            if (whiten_out !== (s ^ k[79:16])) begin
                failures++;
                $display("FAIL rand_whiten%0d: got %h required %h", i, whiten_out, s ^ k[79:16]);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || state_out !== es || key_out !== ek) begin
                failures++;
                $display("FAIL rand_round%0d: state=%h key=%h v=%b, required %h %h 1",
                         i, state_out, key_out, out_valid, es, ek);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] s, es;
        logic [79:0] k, ek;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            state_in = {$urandom, $urandom}; key_in = rand_key(); rc = 5'(r); in_valid = 1'b1;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_out !== 64'h0 || key_out !== 80'h0) begin
            failures++;
            $display("FAIL t5_async_reset: v=%b state=%h key=%h, required 0/0/0",
                     out_valid, state_out, key_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_out !== 64'h0 || key_out !== 80'h0) begin
            failures++;
            $display("FAIL t5_reset_hold: v=%b state=%h key=%h, required 0/0/0",
                     out_valid, state_out, key_out);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        // Load a known nonzero result, then idle and confirm it is held
        s = {$urandom, $urandom}; k = rand_key();
        es = m_round(s, k); ek = m_key(k, 5'd9);
        @(negedge clk);
        state_in = s; key_in = k; rc = 5'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        state_in = {$urandom, $urandom}; key_in = rand_key();
        checks++;
        if (out_valid !== 1'b1 || state_out !== es || key_out !== ek) begin
            failures++;
            $display("FAIL t5_post_reset_round: state=%h key=%h v=%b, required %h %h 1",
                     state_out, key_out, out_valid, es, ek);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || state_out !== es || key_out !== ek) begin
                failures++;
                $display("FAIL t5_idle_hold%0d: state=%h key=%h v=%b, required %h %h 0",
                         c, state_out, key_out, out_valid, es, ek);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q_s [$];
        logic [79:0] q_k [$];
        logic [63:0] s, es;
        logic [79:0] k, ek;
        logic [4:0]  r;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                es = q_s.pop_front(); ek = q_k.pop_front();
                checks++;
                if (out_valid !== 1'b1 || state_out !== es || key_out !== ek) begin
                    failures++;
                    $display("FAIL t6_b2b%0d: state=%h key=%h v=%b, required %h %h 1",
                             i, state_out, key_out, out_valid, es, ek);
                end
            end
            if (i < 20) begin
                s = {$urandom, $urandom}; k = rand_key(); r = 5'($urandom_range(1, 31));
                q_s.push_back(m_round(s, k)); q_k.push_back(m_key(k, r));
                state_in = s; key_in = k; rc = r; in_valid = 1'b1;
                #1;
                checks++;
                if (whiten_out !== (s ^ k[79:16])) begin
                    failures++;
                    $display("FAIL t6_whiten%0d: got %h required %h", i, whiten_out, s ^ k[79:16]);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL t6_valid_drop: out_valid=%b required 0", out_valid);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; in_valid = 1'b0;
        state_in = '0; key_in = '0; rc = '0;
        test_reset();
        test_single_round();
        test_full_vectors();
        test_random_rounds();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
